// File: rtl/ysyx_25020047_exu_mc.sv
// Multi-cycle execute unit: single-cycle RV32 integer ops plus iterative
// MUL / DIVU / REMU, with every result registered behind a valid/ready output.
module ysyx_25020047_exu_mc #(
    parameter int XLEN   = 32,
    parameter bit MDU_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_op,
    input  logic [XLEN-1:0] in_rdata1,
    input  logic [XLEN-1:0] in_rdata2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_snpc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_reg_wen,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_ebreak,
    output logic            out_illegal
);

    // One extra bit so the counter can hold XLEN itself without wrapping.
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] C_LOAD = CW'(XLEN);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic            r_wen, r_rd, r_wr, r_eb, r_ill;

    logic            w_fire;
    logic            w_onehot, w_legal;
    logic            w_is_mul, w_is_divu, w_is_remu, w_div0, w_start_mdu;
    logic [XLEN-1:0] w_sum, w_pcimm, w_sc_result, w_mdu_next;
    logic            w_sc_wen, w_sc_rd, w_sc_wr, w_sc_eb;
    logic            w_lt_s_imm, w_lt_u_imm, w_lt_s_reg, w_lt_u_reg, w_eq;

    assign in_ready = (r_state == S_IDLE) || (r_state == S_DONE && out_ready);
    assign w_fire   = in_valid && in_ready;

    // Legal means exactly one bit set, not reserved, and MDU bits only when built in.
    assign w_onehot = (in_op != 32'd0) && ((in_op & (in_op - 32'd1)) == 32'd0);
    assign w_legal  = w_onehot && (in_op[31:22] == 10'd0) && (MDU_EN || (in_op[21:19] == 3'd0));

    assign w_is_mul    = w_legal && in_op[19];
    assign w_is_divu   = w_legal && in_op[20];
    assign w_is_remu   = w_legal && in_op[21];
    assign w_div0      = (in_rdata2 == '0);
    // Divide-by-zero never enters the iterative path; it retires next cycle.
    assign w_start_mdu = w_fire && (w_is_mul || ((w_is_divu || w_is_remu) && !w_div0));

    assign w_sum      = in_rdata1 + in_imm;
    assign w_pcimm    = in_pc + in_imm;
    assign w_lt_s_imm = $signed(in_rdata1) < $signed(in_imm);
    assign w_lt_u_imm = in_rdata1 < in_imm;
    assign w_lt_s_reg = $signed(in_rdata1) < $signed(in_rdata2);
    assign w_lt_u_reg = in_rdata1 < in_rdata2;
    assign w_eq       = in_rdata1 == in_rdata2;

    assign w_sc_rd  = w_legal && (in_op[5] || in_op[6]);
    assign w_sc_wr  = w_legal && (in_op[7] || in_op[8]);
    assign w_sc_eb  = w_legal && in_op[2];
    assign w_sc_wen = w_legal && !(in_op[2] || in_op[7] || in_op[8] || in_op[14] || in_op[15]);

    // Single-cycle result select; illegal codes, ebreak and mul resolve to 0.
    always_comb begin
        w_sc_result = '0;
        if (w_legal) begin
            case (1'b1)
                in_op[0], in_op[5], in_op[6], in_op[7], in_op[8]: w_sc_result = w_sum;
                in_op[1]:            w_sc_result = {w_sum[XLEN-1:1], 1'b0};
                in_op[3]:            w_sc_result = in_rdata1 + in_rdata2;
                in_op[4]:            w_sc_result = in_imm;
                in_op[9], in_op[10]: w_sc_result = w_pcimm;
                in_op[11]:           w_sc_result = in_rdata1 - in_rdata2;
                in_op[12]:           w_sc_result = {{(XLEN-1){1'b0}}, w_lt_s_imm};
                in_op[13]:           w_sc_result = {{(XLEN-1){1'b0}}, w_lt_u_imm};
                in_op[14]:           w_sc_result = w_eq ? w_pcimm : in_snpc;
                in_op[15]:           w_sc_result = w_eq ? in_snpc : w_pcimm;
                in_op[16]:           w_sc_result = {{(XLEN-1){1'b0}}, w_lt_s_reg};
                in_op[17]:           w_sc_result = {{(XLEN-1){1'b0}}, w_lt_u_reg};
                in_op[18]:           w_sc_result = in_rdata1 ^ in_rdata2;
                in_op[20]:           w_sc_result = '1;
                in_op[21]:           w_sc_result = in_rdata1;
                default:             w_sc_result = '0;
            endcase
        end
    end

    generate
        if (MDU_EN) begin : g_mdu
            // r_acc: product accumulator / partial remainder.
            // r_opb: shifted multiplicand / divisor.
            // r_opc: multiplier (shifts right) / dividend-then-quotient (shifts left).
            logic [XLEN-1:0] r_acc, r_opb, r_opc;
            logic            r_mul, r_rem;
            logic [XLEN:0]   w_rem_sh, w_diff;
            logic            w_ge;
            logic [XLEN-1:0] w_acc_n, w_opb_n, w_opc_n;

            // One shift-add or one restoring-divide step, and the value it would retire.
            always_comb begin
                w_rem_sh = {r_acc, r_opc[XLEN-1]};
                w_diff   = w_rem_sh - {1'b0, r_opb};
                w_ge     = ~w_diff[XLEN];
                if (r_mul) begin
                    w_acc_n = r_acc + (r_opc[0] ? r_opb : '0);
                    w_opb_n = r_opb << 1;
                    w_opc_n = r_opc >> 1;
                end else begin
                    w_acc_n = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                    w_opb_n = r_opb;
                    w_opc_n = {r_opc[XLEN-2:0], w_ge};
                end
                w_mdu_next = (r_mul || r_rem) ? w_acc_n : w_opc_n;
            end

            // Operands are captured at the transfer, then stepped once per BUSY cycle.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_acc <= '0;
                    r_opb <= '0;
                    r_opc <= '0;
                    r_mul <= 1'b0;
                    r_rem <= 1'b0;
                end else if (w_start_mdu) begin
                    r_acc <= '0;
                    r_mul <= in_op[19];
                    r_rem <= in_op[21];
                    if (in_op[19]) begin
                        r_opb <= in_rdata1;
                        r_opc <= in_rdata2;
                    end else begin
                        r_opb <= in_rdata2;
                        r_opc <= in_rdata1;
                    end
                end else if (r_state == S_BUSY) begin
                    r_acc <= w_acc_n;
                    r_opb <= w_opb_n;
                    r_opc <= w_opc_n;
                end
            end
        end else begin : g_no_mdu
            assign w_mdu_next = '0;
        end
    endgenerate

    // Control FSM with registered result and flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_wen    <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_eb     <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_fire) begin
                        r_wen <= w_sc_wen;
                        r_rd  <= w_sc_rd;
                        r_wr  <= w_sc_wr;
                        r_eb  <= w_sc_eb;
                        r_ill <= !w_legal;
                        if (w_start_mdu) begin
                            r_state <= S_BUSY;
                            r_cnt   <= C_LOAD;
                            r_valid <= 1'b0;
                        end else begin
                            r_state  <= S_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_sc_result;
                        end
                    end else if (r_state == S_DONE && out_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - C_ONE;
                    if (r_cnt == C_ONE) begin
                        r_state  <= S_DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_mdu_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid     = r_valid;
    assign out_result    = r_result;
    assign out_reg_wen   = r_wen;
    assign out_mem_read  = r_rd;
    assign out_mem_write = r_wr;
    assign out_ebreak    = r_eb;
    assign out_illegal   = r_ill;

endmodule

// File: doc/ysyx_25020047_exu_mc.md
# ysyx_25020047_exu_mc

Multi-cycle, handshaked execute unit that replaces the single-cycle combinational EXU between IDU and LSU/WBU. It takes a one-hot operation code with operands and evaluates all existing RV32 integer ops in one cycle. It adds iterative MUL, DIVU and REMU, and registers every result behind a valid/ready output handshake. Simulation-control side effects become registered flags (`out_ebreak`, `out_illegal`) that the top level forwards to the DPI layer.

## Interface
- `XLEN`, 32: datapath width; must be ≥8 and even.
- `MDU_EN`, 1: when 0, MUL/DIVU/REMU codes are treated as illegal and the iterative datapath is removed.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: request present.
- `in_ready` out 1: EXU accepts; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_op` in 32: one-hot op. Bits 0–18 are addi, jalr, ebreak, add, lui, lw, lbu, sw, sb, auipc, jal, sub, slti, sltiu, beq, bne, slt, sltu, xor. Bit 19 is mul, bit 20 divu, bit 21 remu. Bits 22–31 are reserved.
- `in_rdata1`, `in_rdata2`, `in_imm`, `in_pc`, `in_snpc` in XLEN: operands.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer takes the result.
- `out_result` out XLEN: result, address, or next PC.
- `out_reg_wen`, `out_mem_read`, `out_mem_write` out 1: per-op control, as in the current EXU.
- `out_ebreak`, `out_illegal` out 1: qualified by `out_valid`.

## Operation
- States:
  - IDLE: empty.
  - BUSY: iterating.
  - DONE: result held.
- Transitions:
  - IDLE or DONE, on a transfer of a single-cycle op: go to DONE with registered results.
  - IDLE or DONE, on a transfer of mul, divu or remu (MDU_EN=1, divisor nonzero): go to BUSY.
  - BUSY, after exactly XLEN iterations: go to DONE.
  - DONE, when `out_ready` is high and there is no new transfer: go to IDLE.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). It is combinational and is 0 in BUSY.
- Single-cycle op semantics:
  - addi, lw, lbu, sw, sb: rdata1+imm.
  - jalr: (rdata1+imm) with bit 0 cleared.
  - lui: imm.
  - auipc, jal: pc+imm.
  - add / sub / xor: two-register ops.
  - slt / slti: signed compare. sltu / sltiu: unsigned compare. Each gives 1 or 0.
  - beq / bne: pc+imm if the condition holds, else snpc.
  - Arithmetic is modulo 2^XLEN.
- Control outputs:
  - `reg_wen`=1 for all ops except ebreak, sw, sb, beq, bne.
  - `mem_read`=1 for lw and lbu.
  - `mem_write`=1 for sw and sb.
  - `out_ebreak`=1 only for ebreak, with result 0.
- Illegal `in_op` (zero bits set, more than one bit set, a reserved bit, or an MDU bit with MDU_EN=0):
  - Single-cycle; `out_illegal`=1.
  - result=0 and all write/memory enables are 0.
- mul: shift-add, one multiplier bit per cycle; result is the low XLEN bits of the product.
- divu/remu: restoring division, one quotient bit per cycle.
- Divisor 0 is detected at the transfer and completes single-cycle: divu gives all-ones, remu gives rdata1.
- Operands are captured at the transfer. Input changes during BUSY or DONE have no effect.

## Timing
- Reset:
  - State returns to IDLE from any state, including mid-BUSY; the partial result is discarded.
  - `out_valid`, `out_result`, and all flags are 0.
  - `in_ready`=1 while reset is deasserted in IDLE.
- Latency is counted from the transfer edge T:
  - Single-cycle ops and divide-by-zero: `out_valid` rises at T+1.
  - mul, divu, remu: `out_valid` rises at T+1+XLEN (T+33 for XLEN=32).
- Output stability: outputs are registered and held unchanged while `out_valid && !out_ready`.
- Back-to-back: in DONE with `out_ready`=1 and `in_valid`=1, the old result is consumed and the new op is accepted on the same edge. For single-cycle ops this gives one result per cycle.
- Iteration counter: width is clog2(XLEN)+1. It is loaded at the transfer and must not wrap; exactly XLEN iterations occur.

## Test plan
- Back-to-back single-cycle ops, `out_ready`=1:
  - addi(rdata1=5, imm=-3) -> 2.
  - sltiu(rdata1=1, imm=0xFFFFFFFF) -> 1.
  - beq(rdata1=rdata2, pc=0x80000000, imm=0x10) -> 0x80000010.
  - bne(rdata1=rdata2) -> snpc.
  - Required: one result per cycle, each at T+1.
- mul(0xFFFFFFFF, 3):
  - Result 0xFFFFFFFD at T+33.
  - `in_ready`=0 for cycles T+1..T+32.
- divu(100, 7) -> 14 and remu(100, 7) -> 2, each at T+33.
- divu(5, 0) -> 0xFFFFFFFF and remu(5, 0) -> 5, each at T+1.
- Backpressure and flags:
  - Hold `out_ready`=0 for 5 cycles after a sw: result stays constant, `mem_write`=1, `reg_wen`=0.
  - ebreak: `out_ebreak`=1.
  - `in_op`=0x3: `out_illegal`=1 and result 0.
- Reset mid-operation: assert `reset` at T+10 of a mul. Required: `out_valid`=0 immediately, state IDLE, and the next addi completes normally.
